// File: rtl/noc_packetizer_pkg.sv
// Purpose : shared NoC types (address, header, flit) plus the packetizer state encoding.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package noc_packetizer_pkg;

  localparam int ADDR_W         = 4;
  localparam int FLIT_PAYLOAD_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
  } addr_t;

  // Header payload layout; zero-extended into the flit payload field.
  typedef struct packed {
    addr_t dst_addr;
    addr_t src_addr;
  } flit_hdr_t;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2
  } flit_type_t;

  typedef struct packed {
    flit_type_t                ftype;
    logic [FLIT_PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    ZTAIL,
    DRAIN
  } pkt_state_t;

endpackage

// File: rtl/noc_packetizer_if.sv
// Purpose : command, payload and router-side flit signals of the packetizer.
// Latency : n/a (wiring only).
// Backpressure: cmd/data use valid/ready; flit side uses enable/ack.
// Modports: master = packetizer (drives cmd_ready, data_ready, flit, enable, busy);
//           slave  = client plus router (drives cmd_*, data*, ack).
interface noc_packetizer_if #(
  parameter int MAX_LEN = 16
);
  import noc_packetizer_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                      cmd_valid;
  logic                      cmd_ready;
  addr_t                     cmd_dst;
  logic [LEN_W-1:0]          cmd_len;
  logic                      data_valid;
  logic                      data_ready;
  logic [FLIT_PAYLOAD_W-1:0] data;
  flit_t                     flit;
  logic                      enable;
  logic                      ack;
  logic                      busy;

  modport master (
    input  cmd_valid, cmd_dst, cmd_len, data_valid, data, ack,
    output cmd_ready, data_ready, flit, enable, busy
  );

  modport slave (
    output cmd_valid, cmd_dst, cmd_len, data_valid, data, ack,
    input  cmd_ready, data_ready, flit, enable, busy
  );

endinterface

// File: rtl/noc_out_reg.sv
// Purpose : one-entry registered flit/enable holder in front of a router input port.
// Latency : 1 cycle from load to enable.
// Backpressure: accepts a new flit only when free (!enable || ack); holds flit/enable while stalled.
// Ports: load/load_flit (new flit request), ack (router accept), free (slot can take
//        a flit this cycle), flit/enable (registered outputs to the router).
module noc_out_reg (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  noc_packetizer_pkg::flit_t load_flit,
  input  logic                     ack,
  output logic                     free,
  output noc_packetizer_pkg::flit_t flit,
  output logic                     enable
);

  assign free = !enable || ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit   <= '0;
      enable <= 1'b0;
    end else if (free) begin
      enable <= load;
      if (load) begin
        flit <= load_flit;
      end
    end
  end

endmodule

// File: rtl/noc_packetizer.sv
// Purpose : builds one wormhole packet (HEADER, BODY*, TAIL) per command from a payload stream.
// Latency : HEADER valid the cycle after command accept; then up to 1 flit/cycle.
// Backpressure: data_ready follows the output slot being free; enable/flit hold while ack is low.
// Ports: clk, rst (async, active-high); bus = noc_packetizer_if.master (cmd, data, flit, busy).
// Optional: NOC_PACKETIZER_STATS_EN adds stats_clr, pkt_cnt[31:0], flit_cnt[31:0].
module noc_packetizer #(
  parameter int X       = 1,
  parameter int Y       = 1,
  parameter int MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef NOC_PACKETIZER_STATS_EN
  input  logic        stats_clr,
  output logic [31:0] pkt_cnt,
  output logic [31:0] flit_cnt,
`endif
  noc_packetizer_if.master bus
);
  import noc_packetizer_pkg::*;

  localparam int               LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam addr_t            SELF      = '{x: ADDR_W'(X), y: ADDR_W'(Y)};

  pkt_state_t       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] len_c;
  logic             load;
  flit_t            load_flit;
  logic             free;
  logic             cmd_rdy;
  logic             data_rdy;
  flit_hdr_t        hdr;

  noc_out_reg u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_flit(load_flit),
    .ack      (bus.ack),
    .free     (free),
    .flit     (bus.flit),
    .enable   (bus.enable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    load         = 1'b0;
    load_flit    = '0;
    cmd_rdy      = 1'b0;
    data_rdy     = 1'b0;
    len_c        = (bus.cmd_len > MAX_LEN_L) ? MAX_LEN_L : bus.cmd_len;
    hdr.dst_addr = bus.cmd_dst;
    hdr.src_addr = SELF;

    case (state_q)
      // Output slot is always empty here: DRAIN only leaves after the TAIL ack.
      IDLE: begin
        cmd_rdy = 1'b1;
        if (bus.cmd_valid) begin
          load                                   = 1'b1;
          load_flit.ftype                        = HEADER;
          load_flit.payload[$bits(flit_hdr_t)-1:0] = hdr;
          rem_d                                  = len_c;
          state_d = (len_c != '0) ? PAYLOAD : ZTAIL;
        end
      end
      PAYLOAD: begin
        data_rdy = free;
        if (bus.data_valid && free) begin
          load              = 1'b1;
          load_flit.ftype   = (rem_q > LEN_W'(1)) ? BODY : TAIL;
          load_flit.payload = bus.data;
          rem_d             = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      // Zero-length message still needs a TAIL to close the wormhole.
      ZTAIL: begin
        if (free) begin
          load            = 1'b1;
          load_flit.ftype = TAIL;
          state_d         = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.enable && bus.ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst so the handshake outputs read 0 while reset is held.
  assign bus.cmd_ready  = cmd_rdy && !rst;
  assign bus.data_ready = data_rdy && !rst;
  assign bus.busy       = (state_q != IDLE);

`ifdef NOC_PACKETIZER_STATS_EN
  logic xfer;
  assign xfer = bus.enable && bus.ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
    end else if (stats_clr) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
    end else begin
      if (xfer) begin
        flit_cnt <= flit_cnt + 32'd1;
      end
      if (xfer && bus.flit.ftype == TAIL) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
    end
  end
`endif

  a_len_range: assert property (@(posedge clk) disable iff (rst)
    (bus.cmd_valid && bus.cmd_ready) |-> (bus.cmd_len <= MAX_LEN_L));

  a_dst_not_self: assert property (@(posedge clk) disable iff (rst)
    (bus.cmd_valid && bus.cmd_ready) |-> (bus.cmd_dst != SELF));

endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
- Network-interface transmit stage; feeds one router input port (flit/enable/ack, down side of the router).
- Accepts a message command (destination, length) plus a stream of payload words.
- Emits one wormhole packet: HEADER, zero or more BODY flits, then TAIL.
- Output side is fully registered, so enable never depends combinationally on ack.

Parameters:
- X, 1, column coordinate of the attached router; written into the header src_addr.x.
- Y, 1, row coordinate of the attached router; written into the header src_addr.y.
- MAX_LEN, 16, maximum payload words per packet. Must be at least 1.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_dst  in  $bits(addr_t)  destination router address.
- cmd_len  in  LEN_W  payload word count, range 0..MAX_LEN.
- data_valid  in  1  payload word present.
- data_ready  out  1  word consumed when data_valid && data_ready.
- data  in  FLIT_PAYLOAD_W  payload word.
- flit  out  $bits(flit_t)  flit to router.
- enable  out  1  flit valid.
- ack  in  1  router accepts; transfer occurs when enable && ack.
- busy  out  1  high from command accept until the TAIL transfer completes.

Behaviour:
- Reset values: cmd_ready=0, data_ready=0, enable=0, flit=0, busy=0, state=IDLE.
  - Async reset mid-packet drops the packet; no TAIL is emitted.
- Output register:
  - Loads a new flit only when !enable || ack.
  - While enable && !ack, flit and enable hold stable every cycle.
- States:
  - IDLE: cmd_ready=1.
    - On accept: latch dst and len; rem = len.
    - Load HEADER: payload = {dst_addr=cmd_dst, src_addr={X,Y}}; enable=1; busy=1.
    - Next state: PAYLOAD if len>0, else ZTAIL.
  - PAYLOAD: data_ready = (!enable || ack).
    - On a word transfer: load BODY if rem>1, else TAIL.
    - Decrement rem.
    - On rem==1 go to DRAIN.
  - ZTAIL (len==0 only): when the output register is free, load TAIL with payload 0; go to DRAIN.
  - DRAIN: wait for the TAIL transfer (enable && ack).
    - Then enable=0 (unless reloaded), busy=0, go to IDLE.
- cmd_ready is 0 in every state except IDLE. No new command is accepted until the TAIL is acked.
- Back-to-back throughput:
  - 1 flit/cycle when ack is held high and data_valid is held high.
  - Packet length is len+1 flits for len≥1, and 2 flits for len=0.
- Command-to-HEADER latency: HEADER appears with enable=1 on the cycle after cmd accept.
- Same cycle as a HEADER ack, the first payload word may be consumed (register free via ack).
- data_valid low in PAYLOAD: enable drops to 0 after the current flit is acked.
  - Inserting bubbles mid-packet is legal.
- cmd_len > MAX_LEN: clamped to MAX_LEN.
  - Simulation-only assertion fires.
- dst equal to {X,Y}: packet still emitted; simulation-only assertion fires.
- data presented while in IDLE: ignored (data_ready=0).

Optional Feature:
- Macro: NOC_PACKETIZER_STATS_EN.
- Defined:
  - Adds outputs pkt_cnt[31:0] and flit_cnt[31:0], both reset to 0.
  - pkt_cnt increments on each TAIL transfer.
  - flit_cnt increments on each enable && ack.
  - Both wrap modulo 2^32.
  - Adds input stats_clr, a synchronous clear. If clear coincides with an increment, the counter ends at 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared NoC package (existing):
  - flit_t and its flit_type enum {HEADER, BODY, TAIL}.
  - flit_hdr_t with dst_addr and src_addr.
  - addr_t {x,y}.
  - FLIT_PAYLOAD_W.
- Package additions: the packetizer state enum (IDLE, PAYLOAD, ZTAIL, DRAIN).
- Sub-module: noc_out_reg, a one-entry registered flit/enable holder with the load-when-(!enable||ack) rule.
  - Reusable by other NoC sources.

Test Plan:
- Length 3, ack tied high: cmd {dst=(2,1), len=3}, data 0xA,0xB,0xC back-to-back.
  - Expect 4 consecutive transfers: HEADER(dst=(2,1), src=(X,Y)), BODY 0xA, BODY 0xB, TAIL 0xC.
  - busy falls the cycle after the TAIL transfer.
- Backpressure: same packet with ack low for 3 cycles while HEADER is presented.
  - flit/enable stable for all 3 cycles; data_ready=0.
  - Sequence unchanged after ack rises.
- Zero length: cmd len=0 → HEADER then TAIL(payload 0).
  - data_ready never asserted; cmd_ready returns after the TAIL ack.
- Data bubbles: len=2, data_valid low for 2 cycles between words.
  - enable=0 during the gap; output is BODY w0, TAIL w1 in order.
- Reset mid-packet: assert rst after the BODY transfer of a len=4 packet.
  - All outputs 0 immediately.
  - After release, a new cmd len=1 yields HEADER, TAIL only.
- Stats (with NOC_PACKETIZER_STATS_EN): two packets of len 3 and len 0.
  - Expect pkt_cnt=2, flit_cnt=6.
  - stats_clr pulse → both 0 the next cycle.
